gpio_irq: RTL

- Parametrised successor to the fixed-configuration GPIO peripheral.
- Provides CH bidirectional pins with per-pin direction and atomic set/clear/toggle of output bits.
- Adds a synchronised input path, per-pin rising/falling edge detection, a write-1-to-clear interrupt status register and a level interrupt output to the interrupt controller.
- Sits on the peripheral bus beside the timer and UART, using the same cs_/as_/rw/rdy_ bus protocol.

---
 rtl/gpio_irq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/gpio_irq.sv
// GPIO block with per-pin direction, set/clear/toggle output, synchronised inputs,
// edge-triggered W1C interrupt status and level irq. Optional filter: GPIO_DEBOUNCE_EN.
module gpio_irq #(
    parameter int CH         = 8,
    parameter int DEB_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs_,
    input  logic          as_,
    input  logic          rw,
    input  logic [3:0]    addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    output logic          rdy_,
    inout  logic [CH-1:0] gpio_io,
    output logic          irq
);

    localparam logic [3:0] A_IN       = 4'd0;
    localparam logic [3:0] A_OUT      = 4'd1;
    localparam logic [3:0] A_OUT_SET  = 4'd2;
    localparam logic [3:0] A_OUT_CLR  = 4'd3;
    localparam logic [3:0] A_OUT_TGL  = 4'd4;
    localparam logic [3:0] A_DIR      = 4'd5;
    localparam logic [3:0] A_RISE_EN  = 4'd6;
    localparam logic [3:0] A_FALL_EN  = 4'd7;
    localparam logic [3:0] A_IRQ_EN   = 4'd8;
    localparam logic [3:0] A_IRQ_STAT = 4'd9;

    logic          access;
    logic          wr_en;
    logic [CH-1:0] wd;
    logic [CH-1:0] out_q;
    logic [CH-1:0] dir_q;
    logic [CH-1:0] rise_en;
    logic [CH-1:0] fall_en;
    logic [CH-1:0] irq_en;
    logic [CH-1:0] irq_stat;
    logic [CH-1:0] s1;
    logic [CH-1:0] s2;
    logic [CH-1:0] in_f;
    logic [CH-1:0] prev;
    logic [CH-1:0] stat_set;
    logic [CH-1:0] w1c;
    logic [CH-1:0] rd_sel;
    logic [31:0]   rd_mux;

    assign access = ~cs_ & ~as_;
    assign wr_en  = access & ~rw;
    assign wd     = wr_data[CH-1:0];

    generate
        if (CH < 32) begin : g_wd_upper
            logic wd_upper_unused;
            assign wd_upper_unused = ^wr_data[31:CH];
        end
    endgenerate

    for (genvar i = 0; i < CH; i++) begin : g_pad
        assign gpio_io[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1   <= '0;
            s2   <= '0;
            prev <= '0;
        end else begin
            s1   <= gpio_io;
            s2   <= s1;
            prev <= in_f;
        end
    end

`ifdef GPIO_DEBOUNCE_EN
    localparam logic [7:0] DEB_TC = 8'(DEB_CYCLES - 1);
    logic [7:0] deb_cnt [CH];

    // in_f only follows s2 after it has disagreed for DEB_CYCLES consecutive clocks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_f <= '0;
            for (int i = 0; i < CH; i++) deb_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (s2[i] != in_f[i]) begin
                    if (deb_cnt[i] == DEB_TC) begin
                        in_f[i]    <= s2[i];
                        deb_cnt[i] <= '0;
                    end else begin
                        deb_cnt[i] <= deb_cnt[i] + 8'd1;
                    end
                end else begin
                    deb_cnt[i] <= '0;
                end
            end
        end
    end
`else
    logic [7:0] deb_param_unused;
    assign deb_param_unused = 8'(DEB_CYCLES);
    assign in_f = s2;
`endif

    assign stat_set = (in_f & ~prev & rise_en) | (~in_f & prev & fall_en);
    assign w1c      = (wr_en && addr == A_IRQ_STAT) ? wd : '0;
    assign irq      = |(irq_stat & irq_en);

    always_comb begin
        rd_sel = '0;
        case (addr)
            A_IN:       rd_sel = in_f;
            A_OUT:      rd_sel = out_q;
            A_DIR:      rd_sel = dir_q;
            A_RISE_EN:  rd_sel = rise_en;
            A_FALL_EN:  rd_sel = fall_en;
            A_IRQ_EN:   rd_sel = irq_en;
            A_IRQ_STAT: rd_sel = irq_stat;
            default:    rd_sel = '0;
        endcase
        rd_mux         = '0;
        rd_mux[CH-1:0] = rd_sel;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data  <= '0;
            rdy_     <= 1'b1;
            out_q    <= '0;
            dir_q    <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
            irq_en   <= '0;
            irq_stat <= '0;
        end else begin
            rdy_     <= ~access;
            rd_data  <= (access & rw) ? rd_mux : '0;
            // a new edge in the same cycle as a W1C keeps the bit set
            irq_stat <= (irq_stat & ~w1c) | stat_set;
            if (wr_en) begin
                case (addr)
                    A_OUT:     out_q   <= wd;
                    A_OUT_SET: out_q   <= out_q | wd;
                    A_OUT_CLR: out_q   <= out_q & ~wd;
                    A_OUT_TGL: out_q   <= out_q ^ wd;
                    A_DIR:     dir_q   <= wd;
                    A_RISE_EN: rise_en <= wd;
                    A_FALL_EN: fall_en <= wd;
                    A_IRQ_EN:  irq_en  <= wd;
                    default:   ;
                endcase
            end
        end
    end

endmodule
